// File: rtl/icx_pixel_capture.sv
// icx_pixel_capture: per-line optical-black averaging, active-window capture with black subtraction, FIFO stream out
module icx_pixel_capture #(
  parameter int DATA_W     = 12,
  parameter int OB_LOG2    = 4,
  parameter int H_FIRST    = 396,
  parameter int H_LAST     = 1091,
  parameter int V_FIRST    = 8,
  parameter int V_LAST     = 1047,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [11:0]       hpos,
  input  logic [11:0]       vpos,
  input  logic              hblank,
  input  logic              cob,
  input  logic              frame_sync,
  input  logic [DATA_W-1:0] adc_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_sol,
  output logic              m_sof,
  output logic [DATA_W-1:0] black_level,
  output logic              overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int ACC_W = DATA_W + OB_LOG2;
  localparam logic [11:0] HF = 12'(H_FIRST);
  localparam logic [11:0] HL = 12'(H_LAST);
  localparam logic [11:0] VF = 12'(V_FIRST);
  localparam logic [11:0] VL = 12'(V_LAST);
  // timing-generator inputs are retimed once before any decode
  logic [11:0] hpos_r, vpos_r;
  logic hblank_r, cob_r, fs_r;
  logic [DATA_W-1:0] adc_r;
  always_ff @(posedge clk)
    if (reset) begin
      hpos_r <= '0;
      vpos_r <= '0;
      hblank_r <= 1'b0;
      cob_r <= 1'b0;
      fs_r <= 1'b0;
      adc_r <= '0;
    end else begin
      hpos_r <= hpos;
      vpos_r <= vpos;
      hblank_r <= hblank;
      cob_r <= cob;
      fs_r <= frame_sync;
      adc_r <= adc_data;
    end
  logic line_ok, cap, sol, sof;
  assign line_ok = vpos_r >= VF && vpos_r <= VL;
  assign cap = line_ok && !hblank_r && hpos_r >= HF && hpos_r <= HL;
  logic [ACC_W-1:0] acc;
  logic [OB_LOG2:0] ob_cnt;
  logic cob_d;
  // ob_cnt MSB set means exactly 2^OB_LOG2 samples were taken
  always_ff @(posedge clk)
    if (reset) begin
      acc <= '0;
      ob_cnt <= '0;
      cob_d <= 1'b0;
      black_level <= '0;
    end else begin
      cob_d <= cob_r;
      if (cob_d && !cob_r) begin
        if (ob_cnt[OB_LOG2]) black_level <= acc[ACC_W-1:OB_LOG2];
        acc <= '0;
        ob_cnt <= '0;
      end else if (cob_r && !ob_cnt[OB_LOG2]) begin
        acc <= acc + ACC_W'(adc_r);
        ob_cnt <= ob_cnt + (OB_LOG2+1)'(1);
      end
    end
  logic cap_prev, first_of_frame;
  assign sol = cap && !cap_prev;
  assign sof = cap && first_of_frame;
  always_ff @(posedge clk)
    if (reset) begin
      cap_prev <= 1'b0;
      first_of_frame <= 1'b1;
    end else begin
      cap_prev <= fs_r ? 1'b0 : cap;
      first_of_frame <= fs_r ? 1'b1 : cap ? 1'b0 : first_of_frame;
    end
  logic [DATA_W-1:0] s1_d, s2_d;
  logic s1_cap, s1_sol, s1_sof, s2_vld, s2_sol, s2_sof;
  always_ff @(posedge clk)
    if (reset) begin
      s1_d <= '0;
      s1_cap <= 1'b0;
      s1_sol <= 1'b0;
      s1_sof <= 1'b0;
      s2_d <= '0;
      s2_vld <= 1'b0;
      s2_sol <= 1'b0;
      s2_sof <= 1'b0;
    end else begin
      s1_d <= adc_r;
      s1_cap <= cap;
      s1_sol <= sol;
      s1_sof <= sof;
      s2_d <= s1_d < black_level ? '0 : s1_d - black_level;
      s2_vld <= s1_cap;
      s2_sol <= s1_sol;
      s2_sof <= s1_sof;
    end
  logic [DATA_W+1:0] mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic full, pop, push;
  assign m_valid = wr_ptr != rd_ptr;
  assign full = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
  assign pop = m_valid && m_ready;
  assign push = s2_vld && (!full || pop);
  assign {m_sof, m_sol, m_data} = m_valid ? mem[rd_ptr[AW-1:0]] : '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr[AW-1:0]] <= {s2_sof, s2_sol, s2_d};
  // a drop in the same cycle as frame_sync keeps overflow set
  always_ff @(posedge clk)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
      overflow <= (s2_vld && full && !pop) ? 1'b1 : fs_r ? 1'b0 : overflow;
    end
endmodule
